// File: rtl/virtual_uart_fifo.sv
// virtual_uart_fifo: AXI4-Lite virtual UART with buffered TX/RX byte FIFOs and threshold interrupts.
//   clock_i, reset_ni     : system clock, asynchronous active-low reset
//   int_core_o/int_xdma_o : registered interrupts to the core and to the host (XDMA)
//   int_ack_i[1:0]        : pulse acknowledges, [0] core pending, [1] xdma pending
//   s_axilite_*           : AXI4-Lite slave (AW/W/B write, AR/R read), offsets decoded on addr[4:2]
module virtual_uart_fifo #(
    parameter int         ADDR_WIDTH    = 32,
    parameter int         DATA_WIDTH    = 32,
    parameter int         TX_DEPTH      = 16,
    parameter int         RX_DEPTH      = 16,
    parameter logic [7:0] RX_THRESH_RST = 8'd1
) (
    input  logic                      clock_i,
    input  logic                      reset_ni,
    output logic                      int_core_o,
    output logic                      int_xdma_o,
    input  logic [1:0]                int_ack_i,
    input  logic [ADDR_WIDTH-1:0]     s_axilite_awaddr,
    input  logic [2:0]                s_axilite_awprot,
    input  logic                      s_axilite_awvalid,
    output logic                      s_axilite_awready,
    input  logic [DATA_WIDTH-1:0]     s_axilite_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axilite_wstrb,
    input  logic                      s_axilite_wvalid,
    output logic                      s_axilite_wready,
    output logic [1:0]                s_axilite_bresp,
    output logic                      s_axilite_bvalid,
    input  logic                      s_axilite_bready,
    input  logic [ADDR_WIDTH-1:0]     s_axilite_araddr,
    input  logic [2:0]                s_axilite_arprot,
    input  logic                      s_axilite_arvalid,
    output logic                      s_axilite_arready,
    output logic [DATA_WIDTH-1:0]     s_axilite_rdata,
    output logic [1:0]                s_axilite_rresp,
    output logic                      s_axilite_rvalid,
    input  logic                      s_axilite_rready
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [2:0] A_RX_POP  = 3'd0;
    localparam logic [2:0] A_TX_PUSH = 3'd1;
    localparam logic [2:0] A_STATUS  = 3'd2;
    localparam logic [2:0] A_CTRL    = 3'd3;
    localparam logic [2:0] A_TX_POP  = 3'd4;
    localparam logic [2:0] A_RX_PUSH = 3'd5;
    localparam logic [2:0] A_IRQ_ACK = 3'd6;
    localparam logic [1:0] OKAY      = 2'b00;
    localparam logic [1:0] SLVERR    = 2'b10;

    typedef enum logic {IDLE, RESP} state_t;

    state_t         wstate, rstate;
    logic           aw_held, w_held;
    logic [2:0]     waddr;
    logic [15:0]    wdata_q;
    logic [1:0]     wstrb_q;
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [TAW-1:0] tx_wp, tx_rp;
    logic [RAW-1:0] rx_wp, rx_rp;
    logic [TAW:0]   tx_count;
    logic [RAW:0]   rx_count;
    logic           tx_ovf, rx_ovf;
    logic [7:0]     rx_thresh;
    logic           xdma_ien, core_ien;
    logic           core_pend, xdma_pend;

    logic           do_write, ar_hs;
    logic [2:0]     raddr;
    logic           tx_full, tx_empty, rx_full, rx_empty;
    logic           tx_push_req, rx_push_req, tx_push, rx_push, tx_pop, rx_pop;
    logic           ack_core, ack_xdma, ack_ovf, core_cond;
    logic [7:0]     thr_eff;
    logic [1:0]     bresp_next;
    logic [31:0]    rd_data;
    logic           rd_err;

    // Only addr[4:2], the low data byte pair and wstrb[1:0] carry meaning.
    logic unused_ok;
    assign unused_ok = ^{s_axilite_awaddr[ADDR_WIDTH-1:5], s_axilite_awaddr[1:0], s_axilite_awprot,
                         s_axilite_araddr[ADDR_WIDTH-1:5], s_axilite_araddr[1:0], s_axilite_arprot,
                         s_axilite_wdata[DATA_WIDTH-1:16], s_axilite_wstrb[DATA_WIDTH/8-1:2]};

    // The register effect fires once both AW and W have been captured.
    assign do_write = (wstate == IDLE) && aw_held && w_held;
    assign ar_hs    = (rstate == IDLE) && s_axilite_arvalid && s_axilite_arready;
    assign raddr    = s_axilite_araddr[4:2];

    // Fullness uses the pre-cycle count, so a pop in the same cycle cannot make room.
    assign tx_full  = tx_count == (TAW+1)'(TX_DEPTH);
    assign rx_full  = rx_count == (RAW+1)'(RX_DEPTH);
    assign tx_empty = tx_count == '0;
    assign rx_empty = rx_count == '0;

    assign tx_push_req = do_write && waddr == A_TX_PUSH && wstrb_q[0];
    assign rx_push_req = do_write && waddr == A_RX_PUSH && wstrb_q[0];
    assign tx_push     = tx_push_req && !tx_full;
    assign rx_push     = rx_push_req && !rx_full;
    assign tx_pop      = ar_hs && raddr == A_TX_POP && !tx_empty;
    assign rx_pop      = ar_hs && raddr == A_RX_POP && !rx_empty;

    assign ack_core  = int_ack_i[0] || (do_write && waddr == A_IRQ_ACK && wdata_q[0]);
    assign ack_xdma  = int_ack_i[1] || (do_write && waddr == A_IRQ_ACK && wdata_q[1]);
    assign ack_ovf   = do_write && waddr == A_IRQ_ACK && wdata_q[2];
    assign thr_eff   = rx_thresh == 8'd0 ? 8'd1 : rx_thresh;
    assign core_cond = 8'(rx_count) >= thr_eff;

    always_comb begin
        bresp_next = (waddr == A_TX_PUSH || waddr == A_CTRL || waddr == A_RX_PUSH || waddr == A_IRQ_ACK)
                     && !(tx_push_req && tx_full) && !(rx_push_req && rx_full) ? OKAY : SLVERR;
    end

    // Popping an empty FIFO reports empty with a zero byte rather than stale memory.
    always_comb begin
        rd_err  = !(raddr == A_RX_POP || raddr == A_STATUS || raddr == A_CTRL || raddr == A_TX_POP);
        rd_data = raddr == A_RX_POP ? {rx_empty, 23'b0, rx_empty ? 8'h00 : rx_mem[rx_rp]} :
                  raddr == A_TX_POP ? {tx_empty, 23'b0, tx_empty ? 8'h00 : tx_mem[tx_rp]} :
                  raddr == A_STATUS ? {tx_ovf, rx_ovf, 6'b0, 8'(tx_count), 8'(rx_count), 6'b0, tx_full, rx_full} :
                  raddr == A_CTRL   ? {16'b0, rx_thresh, 6'b0, xdma_ien, core_ien} : 32'h0;
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wstate            <= IDLE;
            s_axilite_awready <= 1'b0;
            s_axilite_wready  <= 1'b0;
            s_axilite_bvalid  <= 1'b0;
            s_axilite_bresp   <= OKAY;
            aw_held           <= 1'b0;
            w_held            <= 1'b0;
            waddr             <= '0;
            wdata_q           <= '0;
            wstrb_q           <= '0;
        end else if (wstate == IDLE) begin
            if (do_write) begin
                aw_held          <= 1'b0;
                w_held           <= 1'b0;
                s_axilite_bvalid <= 1'b1;
                s_axilite_bresp  <= bresp_next;
                wstate           <= RESP;
            end else begin
                if (s_axilite_awvalid && s_axilite_awready) begin
                    aw_held           <= 1'b1;
                    waddr             <= s_axilite_awaddr[4:2];
                    s_axilite_awready <= 1'b0;
                end else if (!aw_held) begin
                    s_axilite_awready <= 1'b1;
                end
                if (s_axilite_wvalid && s_axilite_wready) begin
                    w_held           <= 1'b1;
                    wdata_q          <= s_axilite_wdata[15:0];
                    wstrb_q          <= s_axilite_wstrb[1:0];
                    s_axilite_wready <= 1'b0;
                end else if (!w_held) begin
                    s_axilite_wready <= 1'b1;
                end
            end
        end else if (s_axilite_bready) begin
            s_axilite_bvalid  <= 1'b0;
            s_axilite_awready <= 1'b1;
            s_axilite_wready  <= 1'b1;
            wstate            <= IDLE;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rstate            <= IDLE;
            s_axilite_arready <= 1'b0;
            s_axilite_rvalid  <= 1'b0;
            s_axilite_rdata   <= '0;
            s_axilite_rresp   <= OKAY;
        end else if (rstate == IDLE) begin
            if (ar_hs) begin
                s_axilite_arready <= 1'b0;
                s_axilite_rvalid  <= 1'b1;
                s_axilite_rdata   <= rd_data;
                s_axilite_rresp   <= rd_err ? SLVERR : OKAY;
                rstate            <= RESP;
            end else begin
                s_axilite_arready <= 1'b1;
            end
        end else if (s_axilite_rready) begin
            s_axilite_rvalid  <= 1'b0;
            s_axilite_arready <= 1'b1;
            rstate            <= IDLE;
        end
    end

    // FIFO storage needs no reset: pointers and counts define validity.
    always_ff @(posedge clock_i) begin
        if (tx_push) tx_mem[tx_wp] <= wdata_q[7:0];
        if (rx_push) rx_mem[rx_wp] <= wdata_q[7:0];
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tx_wp      <= '0;
            tx_rp      <= '0;
            rx_wp      <= '0;
            rx_rp      <= '0;
            tx_count   <= '0;
            rx_count   <= '0;
            tx_ovf     <= 1'b0;
            rx_ovf     <= 1'b0;
            rx_thresh  <= RX_THRESH_RST;
            xdma_ien   <= 1'b0;
            core_ien   <= 1'b0;
            core_pend  <= 1'b0;
            xdma_pend  <= 1'b0;
            int_core_o <= 1'b0;
            int_xdma_o <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TAW'(1);
            if (tx_pop)  tx_rp <= tx_rp + TAW'(1);
            if (rx_push) rx_wp <= rx_wp + RAW'(1);
            if (rx_pop)  rx_rp <= rx_rp + RAW'(1);
            tx_count <= tx_count + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
            rx_count <= rx_count + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
            // Set wins over clear for every sticky flag.
            tx_ovf    <= (tx_push_req && tx_full) || (tx_ovf && !ack_ovf);
            rx_ovf    <= (rx_push_req && rx_full) || (rx_ovf && !ack_ovf);
            core_pend <= core_cond || (core_pend && !ack_core);
            xdma_pend <= tx_push || (xdma_pend && !ack_xdma);
            if (do_write && waddr == A_CTRL && wstrb_q[1]) rx_thresh <= wdata_q[15:8];
            if (do_write && waddr == A_CTRL && wstrb_q[0]) {xdma_ien, core_ien} <= wdata_q[1:0];
            int_core_o <= core_pend && core_ien;
            int_xdma_o <= xdma_pend && xdma_ien;
        end
    end
endmodule

// File: tb/tb_virtual_uart_fifo.sv
// tb_virtual_uart_fifo: directed and random checks of virtual_uart_fifo against a queue-based model.
module tb_virtual_uart_fifo;
    localparam int TXD = 16;
    localparam int RXD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  int_ack = 2'b00;
    logic        int_core, int_xdma;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    virtual_uart_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clock_i(clk), .reset_ni(rst_n), .int_core_o(int_core), .int_xdma_o(int_xdma), .int_ack_i(int_ack),
        .s_axilite_awaddr(awaddr), .s_axilite_awprot(awprot), .s_axilite_awvalid(awvalid), .s_axilite_awready(awready),
        .s_axilite_wdata(wdata), .s_axilite_wstrb(wstrb), .s_axilite_wvalid(wvalid), .s_axilite_wready(wready),
        .s_axilite_bresp(bresp), .s_axilite_bvalid(bvalid), .s_axilite_bready(bready),
        .s_axilite_araddr(araddr), .s_axilite_arprot(arprot), .s_axilite_arvalid(arvalid), .s_axilite_arready(arready),
        .s_axilite_rdata(rdata), .s_axilite_rresp(rresp), .s_axilite_rvalid(rvalid), .s_axilite_rready(rready)
    );

    // Reference model: byte queues plus the programmer-visible flags.
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         m_txovf, m_rxovf, m_cien, m_xien, m_cpend, m_xpend;
    logic [7:0] m_thr;

    function automatic bit m_cond();
        return rx_q.size() >= ((m_thr == 0) ? 1 : int'(m_thr));
    endfunction

    function automatic void m_reset();
        tx_q.delete();
        rx_q.delete();
        {m_txovf, m_rxovf, m_cien, m_xien, m_cpend, m_xpend} = '0;
        m_thr = 8'd1;
    endfunction

    function automatic logic [1:0] m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r;
        r = 2'b00;
        case (a[4:2])
            3'd1: if (s[0]) begin
                if (tx_q.size() == TXD) begin m_txovf = 1; r = 2'b10; end
                else begin tx_q.push_back(d[7:0]); m_xpend = 1; end
            end
            3'd3: begin
                if (s[1]) m_thr = d[15:8];
                if (s[0]) {m_xien, m_cien} = d[1:0];
            end
            3'd5: if (s[0]) begin
                if (rx_q.size() == RXD) begin m_rxovf = 1; r = 2'b10; end
                else rx_q.push_back(d[7:0]);
            end
            3'd6: begin
                if (d[0]) m_cpend = 0;
                if (d[1]) m_xpend = 0;
                if (d[2]) begin m_txovf = 0; m_rxovf = 0; end
            end
            default: r = 2'b10;
        endcase
        if (m_cond()) m_cpend = 1;
        return r;
    endfunction

    task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        r = 2'b00;
        d = 32'h0;
        case (a[4:2])
            3'd0: if (rx_q.size() == 0) d = 32'h8000_0000; else d = {24'b0, rx_q.pop_front()};
            3'd4: if (tx_q.size() == 0) d = 32'h8000_0000; else d = {24'b0, tx_q.pop_front()};
            3'd2: d = {m_txovf, m_rxovf, 6'b0, 8'(tx_q.size()), 8'(rx_q.size()), 6'b0,
                       tx_q.size() == TXD, rx_q.size() == RXD};
            3'd3: d = {16'b0, m_thr, 6'b0, m_xien, m_cien};
            default: r = 2'b10;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] r);
        int n;
        bit ad, wd, a_r, w_r, ok;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        ad = 0; wd = 0; n = 0;
        while (!(ad && wd) && n < 40) begin
            @(negedge clk); a_r = awready; w_r = wready;
            @(posedge clk); #1;
            if (a_r && awvalid) begin ad = 1; awvalid = 0; end
            if (w_r && wvalid) begin wd = 1; wvalid = 0; end
            n++;
        end
        awvalid = 0; wvalid = 0; bready = 1; ok = 0; n = 0; r = 2'bxx;
        while (!ok && n < 40) begin
            @(negedge clk);
            if (bvalid) begin ok = 1; r = bresp; end
            @(posedge clk); #1;
            n++;
        end
        bready = 0;
        checks++;
        assert (ok) else begin errors++; $error("FAIL wr_timeout: no write response for addr %h", a); end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        bit done, ok, a_r;
        araddr = a; arvalid = 1; done = 0; n = 0;
        while (!done && n < 40) begin
            @(negedge clk); a_r = arready;
            @(posedge clk); #1;
            if (a_r) begin done = 1; arvalid = 0; end
            n++;
        end
        arvalid = 0; rready = 1; ok = 0; n = 0; d = 'x; r = 'x;
        while (!ok && n < 40) begin
            @(negedge clk);
            if (rvalid) begin ok = 1; d = rdata; r = rresp; end
            @(posedge clk); #1;
            n++;
        end
        rready = 0;
        checks++;
        assert (ok) else begin errors++; $error("FAIL rd_timeout: no read response for addr %h", a); end
    endtask

    task automatic wrc(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [1:0] r);
        logic [1:0] e;
        e = m_write(a, d, s);
        wr(a, d, s, r);
        chk({tag, ".bresp"}, 32'(r), 32'(e));
    endtask

    task automatic rdc(input string tag, input logic [31:0] a, output logic [31:0] d);
        logic [31:0] ed;
        logic [1:0]  er, r;
        m_read(a, ed, er);
        rd(a, d, r);
        chk({tag, ".rdata"}, d, ed);
        chk({tag, ".rresp"}, 32'(r), 32'(er));
    endtask

    task automatic chk_int(input string tag);
        chk({tag, ".int_core"}, 32'(int_core), 32'(m_cpend & m_cien));
        chk({tag, ".int_xdma"}, 32'(int_xdma), 32'(m_xpend & m_xien));
    endtask

    task automatic ack_pulse(input logic [1:0] v);
        int_ack = v;
        if (v[0]) m_cpend = m_cond();
        if (v[1]) m_xpend = 0;
        @(posedge clk); #1;
        int_ack = 2'b00;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, ed, a;
        logic [1:0]  br, er, ew;
        bit          seen;
        int          n;
        m_reset();
        idle(3);
        chk("rst.awready", 32'(awready), 0);
        chk("rst.arready", 32'(arready), 0);
        chk("rst.bvalid", 32'(bvalid), 0);
        chk("rst.rvalid", 32'(rvalid), 0);
        rst_n = 1;
        idle(2);

        // Reset state
        rdc("t1.status", 32'h08, d);
        chk("t1.status_zero", d, 32'h0);
        chk_int("t1");
        rdc("t1.ctrl", 32'h0C, d);
        chk("t1.ctrl_rst", d, 32'h0000_0100);

        // TX path, xdma interrupt, empty pop
        wrc("t2.ctrl", 32'h0C, 32'h0000_0102, 4'hF, br);
        wrc("t2.push41", 32'h04, 32'h41, 4'hF, br);
        wrc("t2.push42", 32'h04, 32'h42, 4'hF, br);
        idle(2);
        chk("t2.int_xdma", 32'(int_xdma), 1);
        chk_int("t2");
        rdc("t2.status", 32'h08, d);
        chk("t2.tx_count", 32'(d[23:16]), 2);
        rdc("t2.pop1", 32'h10, d);
        chk("t2.pop1_const", d, 32'h41);
        rdc("t2.pop2", 32'h10, d);
        chk("t2.pop2_const", d, 32'h42);
        rdc("t2.pop_empty", 32'h10, d);
        chk("t2.pop_empty_const", d, 32'h8000_0000);
        wrc("t2.nostrb", 32'h04, 32'h77, 4'hE, br);
        chk("t2.nostrb_okay", 32'(br), 0);

        // RX overflow and ovf clear
        for (int i = 0; i < RXD; i++) wrc("t3.fill", 32'h14, $urandom, 4'hF, br);
        wrc("t3.overflow", 32'h14, 32'hEE, 4'hF, br);
        chk("t3.slverr", 32'(br), 2);
        rdc("t3.status", 32'h08, d);
        chk("t3.rx_ovf", 32'(d[30]), 1);
        chk("t3.rx_full", 32'(d[0]), 1);
        wrc("t3.ack_ovf", 32'h18, 32'h4, 4'hF, br);
        rdc("t3.status2", 32'h08, d);
        chk("t3.ovf_clear", 32'(d[31:30]), 0);

        // Core threshold interrupt
        for (int i = 0; i < RXD; i++) rdc("t4.drain", 32'h00, d);
        wrc("t4.ack", 32'h18, 32'h1, 4'hF, br);
        wrc("t4.ctrl", 32'h0C, 32'h0000_0303, 4'hF, br);
        wrc("t4.push1", 32'h14, 32'h11, 4'hF, br);
        wrc("t4.push2", 32'h14, 32'h22, 4'hF, br);
        idle(2);
        chk("t4.below_thresh", 32'(int_core), 0);
        wrc("t4.push3", 32'h14, 32'h33, 4'hF, br);
        idle(2);
        chk("t4.at_thresh", 32'(int_core), 1);
        ack_pulse(2'b01);
        idle(2);
        chk("t4.ack_held", 32'(int_core), 1);
        rdc("t4.pop", 32'h00, d);
        ack_pulse(2'b01);
        idle(2);
        chk("t4.ack_clear", 32'(int_core), 0);
        chk_int("t4");

        // W three cycles ahead of AW, bready held off
        ew = m_write(32'h04, 32'h5A, 4'hF);
        awaddr = 32'h04; wdata = 32'h5A; wstrb = 4'hF; wvalid = 1;
        @(negedge clk); seen = wready;
        @(posedge clk); #1; wvalid = 0;
        chk("t5.wready", 32'(seen), 1);
        idle(2);
        awvalid = 1;
        @(negedge clk); seen = awready;
        @(posedge clk); #1; awvalid = 0;
        chk("t5.awready", 32'(seen), 1);
        n = 0; seen = 0;
        while (!seen && n < 20) begin @(negedge clk); seen = bvalid; n++; end
        chk("t5.bvalid_rise", 32'(seen), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5.bvalid_hold", 32'(bvalid), 1);
            chk("t5.bresp_hold", 32'(bresp), 32'(ew));
        end
        bready = 1;
        @(posedge clk); #1; bready = 0;
        @(negedge clk);
        chk("t5.bvalid_drop", 32'(bvalid), 0);
        idle(1);
        rdc("t5.status", 32'h08, d);
        chk("t5.single_push", 32'(d[23:16]), 1);

        // Simultaneous TX push and pop at count 5
        for (int i = 0; i < 4; i++) wrc("t6.fill", 32'h04, 32'hA0 + i, 4'hF, br);
        chk("t6.awready", 32'(awready), 1);
        chk("t6.arready", 32'(arready), 1);
        m_read(32'h10, ed, er);
        ew = m_write(32'h04, 32'h99, 4'hF);
        awaddr = 32'h04; wdata = 32'h99; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; araddr = 32'h10; arvalid = 1;
        @(posedge clk); #1;
        arvalid = 0;
        @(negedge clk);
        chk("t6.bvalid", 32'(bvalid), 1);
        chk("t6.rvalid", 32'(rvalid), 1);
        chk("t6.rdata", rdata, ed);
        chk("t6.bresp", 32'(bresp), 32'(ew));
        bready = 1; rready = 1;
        @(posedge clk); #1;
        bready = 0; rready = 0;
        rdc("t6.status", 32'h08, d);
        chk("t6.count5", 32'(d[23:16]), 5);
        for (int i = 0; i < 5; i++) rdc("t6.order", 32'h10, d);
        wrc("t6.unmapped_wr", 32'h1C, 32'h1, 4'hF, br);
        chk("t6.unmapped_wr_slverr", 32'(br), 2);
        rdc("t6.unmapped_rd", 32'h1C, d);

        // Random traffic against the model
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1: wrc("rnd.txpush", 32'h04, $urandom, 4'hF, br);
                2, 3: wrc("rnd.rxpush", 32'h14, $urandom, 4'hF, br);
                4:    rdc("rnd.rxpop", 32'h00, d);
                5:    rdc("rnd.txpop", 32'h10, d);
                6:    rdc("rnd.status", 32'h08, d);
                7:    wrc("rnd.ack", 32'h18, 32'($urandom_range(0, 7)), 4'hF, br);
                8:    wrc("rnd.ctrl", 32'h0C, {16'b0, 8'($urandom_range(0, 5)), 6'b0, 2'($urandom_range(0, 3))}, 4'hF, br);
                default: begin
                    a = {27'b0, 3'($urandom_range(0, 7)), 2'b00};
                    if ($urandom_range(0, 1) == 1) wrc("rnd.any_wr", a, $urandom, 4'($urandom_range(0, 15)), br);
                    else rdc("rnd.any_rd", a, d);
                end
            endcase
            idle(2);
            chk_int("rnd");
        end

        // Reset while a write response is outstanding
        wrc("rst_mid.push", 32'h04, 32'h5, 4'hF, br);
        awaddr = 32'h04; wdata = 32'h6; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        idle(4);
        awvalid = 0; wvalid = 0;
        rst_n = 0;
        #1;
        chk("rst_mid.bvalid", 32'(bvalid), 0);
        chk("rst_mid.int_xdma", 32'(int_xdma), 0);
        idle(2);
        rst_n = 1;
        m_reset();
        idle(2);
        rdc("rst_mid.status", 32'h08, d);
        chk("rst_mid.status_zero", d, 32'h0);
        rdc("rst_mid.ctrl", 32'h0C, d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
